// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding memory fetch with a registered output,
// a one-entry skid buffer for decode backpressure, and branch redirect handling.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [31:0] instr_word,
    output logic [31:0] instr_pc,
    output logic [6:0]  opcode
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_HOLD} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] instr_word_q, instr_word_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] skid_word_q, skid_word_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        out_free;
    logic        consume;

    assign consume  = instr_valid_q & instr_ready;
    assign out_free = ~instr_valid_q | instr_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ: begin
                if (redirect_valid) state_d = S_REQ;
                else if (imem_gnt)  state_d = S_WAIT;
            end
            S_WAIT: begin
                if (redirect_valid)   state_d = imem_rvalid ? S_REQ : S_DROP;
                else if (imem_rvalid) state_d = out_free ? S_REQ : S_HOLD;
            end
            // A redirect here only retargets pc; the outstanding return must still be eaten
            S_DROP: begin
                if (imem_rvalid) state_d = S_REQ;
            end
            S_HOLD: begin
                if (redirect_valid || instr_ready) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    always_comb begin
        imem_req    = (state_q == S_REQ) && !rst;
        imem_addr   = pc_q;
        instr_valid = instr_valid_q;
        instr_word  = instr_word_q;
        instr_pc    = instr_pc_q;
        opcode      = instr_word_q[6:0];
    end

    always_comb begin
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        instr_word_d  = instr_word_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        skid_word_d   = skid_word_q;
        skid_pc_d     = skid_pc_q;
        if (redirect_valid) begin
            pc_d          = redirect_pc & ~32'h3;
            instr_valid_d = 1'b0;
            skid_word_d   = '0;
            skid_pc_d     = '0;
        end else begin
            if (consume) instr_valid_d = 1'b0;
            case (state_q)
                S_REQ: begin
                    if (imem_gnt) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + 32'd4;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (out_free) begin
                            instr_word_d  = imem_rdata;
                            instr_pc_d    = req_pc_q;
                            instr_valid_d = 1'b1;
                        end else begin
                            skid_word_d = imem_rdata;
                            skid_pc_d   = req_pc_q;
                        end
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        instr_word_d  = skid_word_q;
                        instr_pc_d    = skid_pc_q;
                        instr_valid_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            req_pc_q      <= '0;
            instr_word_q  <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            skid_word_q   <= '0;
            skid_pc_q     <= '0;
        end else begin
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            instr_word_q  <= instr_word_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            skid_word_q   <= skid_word_d;
            skid_pc_q     <= skid_pc_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations, then randomized
// memory/decode/redirect traffic checked every cycle against a queue-based fetch model.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_gnt, imem_rvalid, redirect_valid, instr_ready;
    logic [31:0] imem_rdata, redirect_pc;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instr_word, instr_pc;
    logic [6:0]  opcode;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_word, w_pc;
    logic [6:0]  w_opcode;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_ready(instr_ready), .instr_valid(instr_valid), .instr_word(instr_word),
        .instr_pc(instr_pc), .opcode(opcode)
    );

    // Same inputs, different reset pc: control flow is identical, only addresses differ
    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_ready(instr_ready), .instr_valid(w_valid), .instr_word(w_word),
        .instr_pc(w_pc), .opcode(w_opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: instructions buffered for decode (head = output register),
    // one in-flight fetch, and a pending-discard flag for a fetch orphaned by a redirect.
    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_infl_pc = 32'h0;
    bit          m_out = 1'b0;
    bit          m_drop = 1'b0;

    function automatic bit m_req();
        return !m_out && !m_drop && (mq.size() < 2);
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                m_pc   = 32'h0;
                m_out  = 1'b0;
                m_drop = 1'b0;
            end else if (redirect_valid) begin
                mq.delete();
                m_pc = {redirect_pc[31:2], 2'b00};
                if (m_out) begin
                    m_out = 1'b0;
                    if (!imem_rvalid) m_drop = 1'b1;
                end else if (m_drop && imem_rvalid) begin
                    m_drop = 1'b0;
                end
            end else begin
                bit hs;
                hs = m_req() && imem_gnt;
                if (mq.size() > 0 && instr_ready) void'(mq.pop_front());
                if (m_drop) begin
                    if (imem_rvalid) m_drop = 1'b0;
                end else if (m_out) begin
                    if (imem_rvalid) begin
                        mq.push_back('{word: imem_rdata, pc: m_infl_pc});
                        m_out = 1'b0;
                    end
                end else if (hs) begin
                    m_out     = 1'b1;
                    m_infl_pc = m_pc;
                    m_pc      = m_pc + 32'd4;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_valid", {31'b0, instr_valid}, 32'h0);
                chk("rst_word", instr_word, 32'h0);
                chk("rst_pc", instr_pc, 32'h0);
                chk("rst_opcode", {25'b0, opcode}, 32'h0);
                chk("rst_req", {31'b0, imem_req}, 32'h0);
            end else begin
                chk("m_req", {31'b0, imem_req}, {31'b0, m_req()});
                if (m_req()) chk("m_addr", imem_addr, m_pc);
                chk("m_valid", {31'b0, instr_valid}, {31'b0, mq.size() > 0});
                if (mq.size() > 0) begin
                    chk("m_word", instr_word, mq[0].word);
                    chk("m_pc", instr_pc, mq[0].pc);
                    chk("m_opcode", {25'b0, opcode}, {25'b0, mq[0].word[6:0]});
                end
            end
        end
    end

    task automatic step(input logic gnt, input logic rv, input logic [31:0] rd,
                        input logic redir, input logic [31:0] rpc, input logic rdy);
        #1;
        imem_gnt       = gnt;
        imem_rvalid    = rv;
        imem_rdata     = rd;
        redirect_valid = redir;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        #1;
    endtask

    bit          mem_busy;
    int unsigned mem_delay;
    bit          last_hs;

    initial begin
        do_reset();
        chk("first_req", {31'b0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, 32'h0);
        chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("wait_req", {31'b0, imem_req}, 32'h0);
        step(1'b0, 1'b1, 32'h0000_0013, 1'b0, 32'h0, 1'b0);
        chk("i0_valid", {31'b0, instr_valid}, 32'h1);
        chk("i0_pc", instr_pc, 32'h0);
        chk("i0_opcode", {25'b0, opcode}, 32'h13);
        chk("addr1", imem_addr, 32'h4);
        chk("wrap_addr1", w_addr, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("i0_consumed", {31'b0, instr_valid}, 32'h0);
        step(1'b0, 1'b1, 32'h0050_0093, 1'b0, 32'h0, 1'b0);
        chk("i1_pc", instr_pc, 32'h4);
        chk("i1_word", instr_word, 32'h0050_0093);
        chk("i1_opcode", {25'b0, opcode}, 32'h13);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h0000_0063, 1'b0, 32'h0, 1'b0);
        chk("i2_pc", instr_pc, 32'h8);
        chk("i2_opcode", {25'b0, opcode}, 32'h63);

        // Backpressure: fetch and return while decode stalls
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h1111_1111, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("hold_word", instr_word, 32'h0000_0063);
            chk("hold_req", {31'b0, imem_req}, 32'h0);
            step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        end
        chk("hold_pc", instr_pc, 32'h8);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("skid_valid", {31'b0, instr_valid}, 32'h1);
        chk("skid_pc", instr_pc, 32'hC);
        chk("skid_word", instr_word, 32'h1111_1111);
        chk("skid_addr", imem_addr, 32'h10);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("skid_consumed", {31'b0, instr_valid}, 32'h0);

        // Redirect while waiting for data
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0102, 1'b1);
        chk("drop_req", {31'b0, imem_req}, 32'h0);
        step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
        chk("drop_valid", {31'b0, instr_valid}, 32'h0);
        chk("drop_req2", {31'b0, imem_req}, 32'h1);
        chk("drop_addr", imem_addr, 32'h100);

        // Redirect coincident with consume and data return
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h2222_2233, 1'b0, 32'h0, 1'b0);
        chk("co_pc", instr_pc, 32'h100);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h3333_3333, 1'b1, 32'h0000_0200, 1'b1);
        chk("co_valid", {31'b0, instr_valid}, 32'h0);
        chk("co_addr", imem_addr, 32'h200);

        // Async reset while a fetch is outstanding
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h4444_4437, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("pre_rst_valid", {31'b0, instr_valid}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("async_valid", {31'b0, instr_valid}, 32'h0);
        chk("async_word", instr_word, 32'h0);
        chk("async_opcode", {25'b0, opcode}, 32'h0);
        chk("async_req", {31'b0, imem_req}, 32'h0);
        imem_gnt = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        step(1'b0, 1'b1, 32'h5555_5555, 1'b0, 32'h0, 1'b1);
        chk("stray_valid", {31'b0, instr_valid}, 32'h0);
        chk("stray_req", {31'b0, imem_req}, 32'h1);
        chk("stray_addr", imem_addr, 32'h0);

        // Randomized traffic; the memory responder honours one response per grant
        mem_busy  = 1'b0;
        mem_delay = 0;
        last_hs   = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic g, rv, rdir, rdy, r;
            #1;
            if (last_hs) begin
                mem_busy  = 1'b1;
                mem_delay = $urandom_range(0, 2);
            end
            rv = 1'b0;
            if (mem_busy) begin
                if (mem_delay == 0) begin
                    rv       = 1'b1;
                    mem_busy = 1'b0;
                end else begin
                    mem_delay--;
                end
            end else begin
                rv = ($urandom_range(0, 23) == 0);
            end
            g    = !mem_busy && ($urandom_range(0, 9) < 7);
            rdir = ($urandom_range(0, 11) == 0);
            rdy  = ($urandom_range(0, 9) < 6);
            r    = (i % 700 == 350);
            last_hs        = imem_req && g && !r;
            imem_gnt       = g;
            imem_rvalid    = rv;
            imem_rdata     = $urandom;
            redirect_valid = rdir;
            redirect_pc    = $urandom;
            instr_ready    = rdy;
            rst            = r;
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 32'h0000_0000, which is the first fetch address after reset (bits [1:0] SHALL be 0).
REQ-002 The port clk SHALL be an input, 1 bit wide, and is the single clock; all state SHALL update on its rising edge.
REQ-003 The port rst SHALL be an input, 1 bit wide; reset is asynchronous and active-high.
REQ-004 The port imem_req SHALL be an output, 1 bit wide, asserted to request a fetch at imem_addr.
REQ-005 The port imem_addr SHALL be an output, 32 bits wide, carrying the word-aligned fetch address.
REQ-006 The port imem_gnt SHALL be an input, 1 bit wide; when high in the same cycle as imem_req, the request is accepted.
REQ-007 The port imem_rvalid SHALL be an input, 1 bit wide, marking the cycle in which the memory returns data.
REQ-008 The port imem_rdata SHALL be an input, 32 bits wide, carrying the returned instruction word.
REQ-009 The port redirect_valid SHALL be an input, 1 bit wide, marking a taken branch or jump from execute.
REQ-010 The port redirect_pc SHALL be an input, 32 bits wide, giving the redirect target.
REQ-011 The port instr_ready SHALL be an input, 1 bit wide, meaning decode accepts the instruction this cycle.
REQ-012 The port instr_valid SHALL be an output, 1 bit wide, meaning the output register holds a valid instruction.
REQ-013 The port instr_word SHALL be an output, 32 bits wide, carrying the fetched instruction.
REQ-014 The port instr_pc SHALL be an output, 32 bits wide, carrying the address of instr_word.
REQ-015 The port opcode SHALL be an output, 7 bits wide, equal to instr_word[6:0] and feeding the control unit's opcode input.

Function
REQ-016 FSM states SHALL be S_REQ, S_WAIT, S_DROP and S_HOLD, with at most one outstanding memory request at any time.
REQ-017 In S_REQ, imem_req=1 and imem_addr=pc; on imem_gnt the block SHALL latch req_pc=pc, set pc=pc+4 (mod 2^32, wrapping from FFFF_FFFC to 0), and go to S_WAIT.
REQ-018 In S_WAIT, imem_req=0; on imem_rvalid with the output register free (instr_valid=0, or instr_ready=1 the same cycle), the block SHALL load instr_word=imem_rdata, instr_pc=req_pc, set instr_valid=1, and go to S_REQ.
REQ-019 In S_WAIT, on imem_rvalid with the output register occupied and instr_ready=0, the block SHALL capture the data into a one-entry skid register and go to S_HOLD.
REQ-020 In S_HOLD, imem_req=0; on instr_ready=1 the block SHALL move the skid entry into the output register in the same edge (instr_valid stays 1) and go to S_REQ.
REQ-021 Output handshake: the instruction is consumed when instr_valid and instr_ready are both 1; if nothing new is loaded that edge, instr_valid SHALL clear next cycle; while instr_ready=0, instr_word and instr_pc SHALL hold stable.
REQ-022 Redirect handling: on redirect_valid the block SHALL set pc={redirect_pc[31:2],2'b00}, clear instr_valid and the skid entry, and take priority over any same-cycle load or consume.
REQ-023 A redirect in S_REQ (grant or no grant), S_HOLD, or S_WAIT with imem_rvalid also high SHALL go to S_REQ next cycle and fetch the new pc; data returned in that cycle SHALL be discarded.
REQ-024 A redirect in S_WAIT without imem_rvalid SHALL go to S_DROP; S_DROP SHALL keep imem_req=0, discard the next imem_rvalid, then go to S_REQ.
REQ-025 A second redirect while in S_DROP SHALL update pc and the block SHALL remain in S_DROP.
REQ-026 imem_rvalid in S_REQ or S_HOLD (a protocol violation) SHALL be ignored.
REQ-027 Best-case throughput SHALL be one instruction per 2 cycles, with a 1-cycle grant and 1-cycle return latency.

Reset
REQ-028 When rst=1, asynchronously: state=S_REQ, pc=RESET_PC, instr_valid=0, instr_word=0, instr_pc=0, opcode=0, skid cleared, imem_req=0; imem_req SHALL assert in the first cycle after rst is released.
REQ-029 Assertion of rst mid-transaction SHALL abandon any outstanding request, and the first imem_rvalid after reset with no new grant SHALL be ignored.

Verification
REQ-030 The bench SHALL cover sequential fetch: RESET_PC=0, with grant and rvalid returning 0x00000013, 0x00500093, 0x00000063 -> instr_pc 0,4,8 in order, with opcode 0x13, 0x13, 0x63.
REQ-031 The bench SHALL cover backpressure: instr_ready=0 for 5 cycles while data is returned -> the block enters S_HOLD, instr_word stays stable, imem_req=0, and no instruction is lost or duplicated after release.
REQ-032 The bench SHALL cover a redirect in S_WAIT: redirect_pc=0x00000102 -> S_DROP, the next rvalid data is discarded, and the next imem_addr=0x00000100.
REQ-033 The bench SHALL cover a redirect coincident with instr_valid&instr_ready and rvalid -> instr_valid=0 next cycle and imem_addr=redirect target.
REQ-034 The bench SHALL cover wrap: RESET_PC=0xFFFFFFFC -> the second fetch address is 0x00000000.
REQ-035 The bench SHALL cover async reset asserted in S_WAIT -> outputs clear immediately without a clock edge, and a stray rvalid after reset release is ignored.
